// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_WIDTH          default operand/result width
//   DIV_ZERO_QUOTIENT  quotient reported when the divisor is zero
//   div_state_e        divider control states
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sub33.sv
// Combinational subtractor: diff = a + ~b + 1 over W bits.
// Ports:
//   a, b    W-bit operands
//   diff    low W-1 bits of the difference
//   borrow  top bit of the difference (set when a < b for in-range operands)
module div_sub33 #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-2:0] diff,
  output logic         borrow
);

  logic [W-1:0] full;

  // Two's complement subtract: ones-complement of b with carry-in of one.
  assign full   = a + ~b + W'(1);
  assign diff   = full[W-2:0];
  assign borrow = full[W-1];

endmodule

// File: rtl/seq_divider.sv
// Multicycle restoring radix-2 divider for MIPS DIV/DIVU (quotient -> LO,
// remainder -> HI). One quotient bit per clock, then a sign fix-up cycle.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (accepted only in IDLE)
//   is_signed             1 = DIV (two's complement), 0 = DIVU
//   dividend, divisor     operands, sampled on the accept edge only
//   out_valid / out_ready result handshake (result held until consumed)
//   quotient, remainder   results
//   div_zero              divisor was zero, qualified by out_valid
// Build option: define SEQ_DIVIDER_EARLY_EXIT_EN to skip the leading-zero
// iterations of the dividend magnitude.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   sub_a, sub_b, neg_b;
  logic [WIDTH-1:0] sub_diff, neg_diff;
  logic             sub_borrow, neg_borrow_unused;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_init;
  logic [CNT_W-1:0] cnt_init;

  // Two subtractors shared across states: in IDLE they form the operand
  // magnitudes, in ITER u_sub is the trial subtract, in FIXUP both negate.
  div_sub33 #(.W(WIDTH + 1)) u_sub (
    .a      (sub_a),
    .b      (sub_b),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  div_sub33 #(.W(WIDTH + 1)) u_neg (
    .a      ('0),
    .b      (neg_b),
    .diff   (neg_diff),
    .borrow (neg_borrow_unused)
  );

  always_comb begin
    sub_a = '0;
    sub_b = {1'b0, dividend};
    neg_b = {1'b0, divisor};
    case (state_q)
      ITER: begin
        sub_a = {rem_q, q_q[WIDTH-1]};
        sub_b = {1'b0, dvsr_q};
      end
      FIXUP: begin
        sub_b = {1'b0, q_q};
        neg_b = {1'b0, rem_q};
      end
      default: ;
    endcase
  end

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? sub_diff : dividend;
  assign dvs_mag = dvs_neg ? neg_diff : divisor;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  logic [CNT_W-1:0] lz;
  logic             lz_found;

  // Zero dividend clamps to WIDTH-1 so one iteration still runs.
  always_comb begin
    lz       = CNT_W'(WIDTH - 1);
    lz_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!lz_found && dvd_mag[WIDTH-1-i]) begin
        lz       = CNT_W'(i);
        lz_found = 1'b1;
      end
    end
  end

  assign q_init   = dvd_mag << lz;
  assign cnt_init = CNT_W'(WIDTH - 1) - lz;
`else
  assign q_init   = dvd_mag;
  assign cnt_init = CNT_W'(WIDTH - 1);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          dvsr_d    = dvs_mag;
          rem_d     = '0;
          cnt_d     = cnt_init;
          dz_d      = 1'b0;
          if (divisor == '0) begin
            q_d     = DIV_ZERO_QUOTIENT;
            rem_d   = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = q_init;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (!sub_borrow) begin
          rem_d = sub_diff;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = sub_a[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIXUP: begin
        q_d     = neg_quo_q ? sub_diff : q_q;
        rem_d   = neg_rem_q ? neg_diff : rem_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results pushed
// at request time and popped when out_valid is observed.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned exp_latency(input logic [W-1:0] mag);
    int unsigned lz;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    lz = W - 1;
    for (int i = W - 1; i >= 0; i--) begin
      if (mag[i]) begin
        lz = W - 1 - i;
        break;
      end
    end
    return W - lz + 2;
`else
    lz = (mag == '0) ? 0 : 0;
    return W + 2 + lz;
`endif
  endfunction

  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic         na, nb;
    logic [W-1:0] ma, mb, mq, mr;
    if (b == '0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
      return e;
    end
    na = s & a[W-1];
    nb = s & b[W-1];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    mq = ma / mb;
    mr = ma % mb;
    e.q   = (na ^ nb) ? (32'd0 - mq) : mq;
    e.r   = na ? (32'd0 - mr) : mr;
    e.dz  = 1'b0;
    e.lat = exp_latency(ma);
    return e;
  endfunction

  // Expected values written out by hand; latency still depends on build option.
  function automatic exp_t lit(input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic dz, input logic [W-1:0] mag);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz;
    e.lat = dz ? 1 : exp_latency(mag);
    return e;
  endfunction

  // Drive one request and return right after the accept edge (+1).
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int unsigned n;
    sb.push_back(e);
    @(negedge clock);
    is_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    // Operands must have been captured on the accept edge.
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // Count cycles from the accept edge until out_valid, then compare.
  task automatic await_result(output int unsigned cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!out_valid && cyc < 200);
  endtask

  task automatic collect(input string tag);
    int unsigned cyc;
    exp_t        e;
    await_result(cyc);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    check_eq({tag, "_q"}, quotient, e.q);
    check_eq({tag, "_r"}, remainder, e.r);
    check_eq({tag, "_dz"}, 32'(div_zero), 32'(e.dz));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input exp_t e);
    issue(s, a, b, e);
    collect(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_q"}, quotient, 32'd0);
    check_eq({tag, "_r"}, remainder, 32'd0);
    check_eq({tag, "_dz"}, 32'(div_zero), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t         e1, e2, e;
    int unsigned  cyc;
    logic         s;
    logic [W-1:0] a, b;

    // Reset state
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Directed cases
    run("divu_100_7", 1'b0, 32'd100, 32'd7, lit(32'd14, 32'd2, 1'b0, 32'd100));
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, lit(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32'd7));
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, lit(32'hFFFF_FFFD, 32'd1, 1'b0, 32'd7));
    run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
        lit(32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000));
    run("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, lit(32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF));
    run("div_by_zero", 1'b0, 32'h1234, 32'd0, lit(32'hFFFF_FFFF, 32'h1234, 1'b1, 32'h1234));
    run("divu_small", 1'b0, 32'd5, 32'd9, lit(32'd0, 32'd5, 1'b0, 32'd5));
    run("divu_5_3", 1'b0, 32'd5, 32'd3, lit(32'd1, 32'd2, 1'b0, 32'd5));
    run("divu_zero_dvd", 1'b0, 32'd0, 32'd3, lit(32'd0, 32'd0, 1'b0, 32'd0));
    run("divu_one_dvd", 1'b0, 32'd1, 32'd1, lit(32'd1, 32'd0, 1'b0, 32'd1));

    // Random cases checked against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 3) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i == 5) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      run("rand", s, a, b, model(s, a, b));
    end

    // Backpressure: in_valid held through ITER/FIXUP/DONE must be ignored;
    // the held request is accepted only on the edge after the consume.
    e1 = model(1'b0, 32'd100, 32'd7);
    e2 = model(1'b1, 32'hFFFF_FFF9, 32'd2);
    @(negedge clock);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock);
    #1;
    is_signed = 1'b1; dividend = 32'hFFFF_FFF9; divisor = 32'd2;
    await_result(cyc);
    check_eq("bp_lat", 32'(cyc), 32'(e1.lat));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_hold_q", quotient, e1.q);
      check_eq("bp_hold_r", remainder, e1.r);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_eq("bp_consume_in_ready", 32'(in_ready), 32'd1);
    check_eq("bp_consume_out_valid", 32'(out_valid), 32'd0);
    sb.push_back(e2);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check_eq("bp_second_accept", 32'(in_ready), 32'd0);
    collect("bp_second");

    // Reset during ITER aborts the operation
    e = model(1'b0, 32'hDEAD_BEEF, 32'd3);
    @(negedge clock);
    is_signed = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (15) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_idle_outputs("abort_after");

    // Normal operation resumes after the abort
    run("post_abort", 1'b0, 32'hDEAD_BEEF, 32'd3, e);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
